// File: rtl/time_set_controller_pkg.sv
// ============================================================================
// time_set_controller_pkg : shared FSM states, targets, field indices and digit limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package time_set_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_H1 = 3'd1,
    ST_EDIT_H0 = 3'd2,
    ST_EDIT_M1 = 3'd3,
    ST_EDIT_M0 = 3'd4,
    ST_COMMIT  = 3'd5
  } state_e;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;

  localparam logic [1:0] FLD_H1 = 2'd0;
  localparam logic [1:0] FLD_H0 = 2'd1;
  localparam logic [1:0] FLD_M1 = 2'd2;
  localparam logic [1:0] FLD_M0 = 2'd3;

  localparam logic [1:0] H1_MAX       = 2'd2;
  localparam logic [3:0] H0_MAX       = 4'd9;
  localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [3:0] M1_MAX       = 4'd5;
  localparam logic [3:0] M0_MAX       = 4'd9;

  function automatic logic [3:0] inc_wrap(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_set_controller_debouncer.sv
// ============================================================================
// time_set_controller_debouncer : 2-flop synchroniser, stability counter, rise pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module time_set_controller_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      pulse_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/time_set_controller.sv
// ============================================================================
// time_set_controller : button-driven HH:MM editor with stretched load strobes
// Optional auto-repeat on btn_up when AUTO_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LOAD_HOLD       = 150_000_000,
  parameter int unsigned TIMEOUT         = 1_000_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       edit_active,
  output logic [1:0] cursor
);

  import time_set_controller_pkg::*;

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(LOAD_HOLD + 1);

  logic mode_level, mode_pulse;
  logic next_level, next_pulse;
  logic up_level,   up_pulse;
  logic rpt_fire;
  logic in_edit;

  state_e            state_q,  state_d;
  target_e           target_q, target_d;
  logic [1:0]        h1_q, h1_d;
  logic [3:0]        h0_q, h0_d;
  logic [3:0]        m1_q, m1_d;
  logic [3:0]        m0_q, m0_d;
  logic [TMO_W-1:0]  tmo_q,  tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  time_set_controller_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_mode), .level(mode_level), .pulse(mode_pulse)
  );
  time_set_controller_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_next), .level(next_level), .pulse(next_pulse)
  );
  time_set_controller_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_up), .level(up_level), .pulse(up_pulse)
  );

  assign in_edit = (state_q == ST_EDIT_H1) || (state_q == ST_EDIT_H0) ||
                   (state_q == ST_EDIT_M1) || (state_q == ST_EDIT_M0);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;

  // First repeat after REPEAT_DELAY, then every REPEAT_CYCLES while still held.
  always_comb begin
    rpt_fire    = 1'b0;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    if (!in_edit || !up_level || up_pulse || next_pulse || mode_pulse) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if (rpt_armed_q ? (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1))
                             : (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1))) begin
      rpt_fire    = 1'b1;
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  logic unused_repeat;
  assign rpt_fire      = 1'b0;
  assign unused_repeat = ^{up_level, REPEAT_DELAY[0], REPEAT_CYCLES[0]};
`endif

  logic unused_mode_level;
  assign unused_mode_level = mode_level;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    tmo_d    = tmo_q;
    hold_d   = '0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (mode_pulse) begin
          state_d  = ST_EDIT_H1;
          target_d = next_level ? TGT_ALARM : TGT_TIME;
        end
      end
      ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
        if (mode_pulse) begin
          state_d = ST_IDLE;
        end else if (next_pulse) begin
          tmo_d = '0;
          case (state_q)
            ST_EDIT_H1: state_d = ST_EDIT_H0;
            ST_EDIT_H0: state_d = ST_EDIT_M1;
            ST_EDIT_M1: state_d = ST_EDIT_M0;
            default:    state_d = ST_COMMIT;
          endcase
        end else if (up_pulse || rpt_fire) begin
          tmo_d = '0;
          case (state_q)
            ST_EDIT_H1: begin
              h1_d = (h1_q >= H1_MAX) ? 2'd0 : h1_q + 2'd1;
              // Keep the hour legal when stepping into the 20s.
              if ((h1_d == H1_MAX) && (h0_q > H0_MAX_AT_20)) begin
                h0_d = H0_MAX_AT_20;
              end
            end
            ST_EDIT_H0: h0_d = inc_wrap(h0_q, (h1_q == H1_MAX) ? H0_MAX_AT_20 : H0_MAX);
            ST_EDIT_M1: m1_d = inc_wrap(m1_q, M1_MAX);
            default:    m0_d = inc_wrap(m0_q, M0_MAX);
          endcase
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (hold_q == HOLD_W'(LOAD_HOLD - 1)) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= TGT_TIME;
      h1_q     <= '0;
      h0_q     <= '0;
      m1_q     <= '0;
      m0_q     <= '0;
      tmo_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_EDIT_H0: cursor = FLD_H0;
      ST_EDIT_M1: cursor = FLD_M1;
      ST_EDIT_M0: cursor = FLD_M0;
      default:    cursor = FLD_H1;
    endcase
  end

  // Strobes decode straight from state so the async reset drops them immediately.
  assign load_time   = (state_q == ST_COMMIT) && (target_q == TGT_TIME);
  assign load_alarm  = (state_q == ST_COMMIT) && (target_q == TGT_ALARM);
  assign edit_active = in_edit;
  assign hour_in1    = h1_q;
  assign hour_in0    = h0_q;
  assign minute_in1  = m1_q;
  assign minute_in0  = m0_q;

endmodule

`default_nettype wire
